march_bist_ctrl: RTL and testbench

March C- BIST controller that sequences the memory-under-test datapath inside the BIST top. On a `start` pulse it walks every address through six March elements (one memory operation per cycle), checks each read, and reports `done`, a sticky `fail`, and diagnostics for the first mismatch. The memory and comparator-side data are external; this block owns addressing, operation order, data background and verdict.

---
 rtl/march_bist_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_march_bist_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/march_bist_ctrl.sv
// rtl/march_bist_ctrl.sv - March C- BIST controller for one memory-under-test
//
// Walks every address through the six March C- elements, one memory
// operation per cycle:
//   M0 up(w0)  M1 up(r0,w1)  M2 up(r1,w0)  M3 dn(r0,w1)  M4 dn(r1,w0)  M5 dn(r0)
// Each read is compared the following cycle. A sticky fail flag is kept,
// and the first mismatch's address and element are captured.
//
// Optional build macro: BIST_EARLY_STOP_EN -- the first mismatch ends the
// run (straight to DONE). Without it the run always completes.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous active-low reset
//   start      in   run request, honoured only in IDLE/DONE
//   mem_addr   out  memory address (combinational from address register)
//   mem_wdata  out  write data, all-0/all-1 background, 0 when not writing
//   mem_we     out  write strobe
//   mem_re     out  read strobe, mem_rdata valid the following cycle
//   mem_rdata  in   read data, one-cycle latency
//   busy       out  run in progress (includes the final compare cycle)
//   done       out  run complete, held until the next accepted start
//   fail       out  sticky mismatch flag, cleared on accepted start
//   fail_addr  out  address of first failing read
//   fail_elem  out  March element (0-5) of first failing read

module march_bist_ctrl #(
  parameter int data_width = 4,
  parameter int ad_width   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ad_width-1:0]   mem_addr,
  output logic [data_width-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [data_width-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ad_width-1:0]   fail_addr,
  output logic [2:0]            fail_elem
);

  localparam logic [ad_width-1:0] ADDR_LAST = {ad_width{1'b1}};
  localparam logic [ad_width-1:0] ADDR_ZERO = '0;
  localparam logic [ad_width-1:0] ADDR_ONE  = {{(ad_width-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    S_IDLE, S_M0,
    S_M1R, S_M1W, S_M2R, S_M2W,
    S_M3R, S_M3W, S_M4R, S_M4W,
    S_M5, S_DRAIN, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [ad_width-1:0] addr_q, addr_d;
  logic                fail_q, fail_d;
  logic [ad_width-1:0] fail_addr_q, fail_addr_d;
  logic [2:0]          fail_elem_q, fail_elem_d;
  // Read issued last cycle: what to expect and where it came from.
  logic                rd_pend_q, rd_pend_d;
  logic                rd_exp_q, rd_exp_d;
  logic [ad_width-1:0] rd_addr_q, rd_addr_d;
  logic [2:0]          rd_elem_q, rd_elem_d;

  // Per-state decode of the current March operation.
  logic                is_rd, is_wr, bg, up;
  logic [2:0]          elem;
  logic [ad_width-1:0] reload;
  logic                last_op, at_end, mismatch;

  always_comb begin
    is_rd  = 1'b0;
    is_wr  = 1'b0;
    bg     = 1'b0;
    up     = 1'b1;
    elem   = 3'd0;
    reload = ADDR_ZERO;
    case (state_q)
      S_M0:  begin is_wr = 1'b1; end
      S_M1R: begin elem = 3'd1; is_rd = 1'b1; end
      S_M1W: begin elem = 3'd1; is_wr = 1'b1; bg = 1'b1; end
      S_M2R: begin elem = 3'd2; is_rd = 1'b1; bg = 1'b1; end
      S_M2W: begin elem = 3'd2; is_wr = 1'b1; reload = ADDR_LAST; end
      S_M3R: begin elem = 3'd3; is_rd = 1'b1; up = 1'b0; end
      S_M3W: begin elem = 3'd3; is_wr = 1'b1; bg = 1'b1; up = 1'b0; reload = ADDR_LAST; end
      S_M4R: begin elem = 3'd4; is_rd = 1'b1; bg = 1'b1; up = 1'b0; end
      S_M4W: begin elem = 3'd4; is_wr = 1'b1; up = 1'b0; reload = ADDR_LAST; end
      S_M5:  begin elem = 3'd5; is_rd = 1'b1; up = 1'b0; end
      default: ;
    endcase
  end

  // The address moves only after the final operation at that address.
  assign last_op  = is_wr || (state_q == S_M5);
  assign at_end   = up ? (addr_q == ADDR_LAST) : (addr_q == ADDR_ZERO);
  assign mismatch = rd_pend_q && (mem_rdata != {data_width{rd_exp_q}});

  assign mem_addr  = addr_q;
  assign mem_we    = is_wr;
  assign mem_re    = is_rd;
  assign mem_wdata = is_wr ? {data_width{bg}} : '0;
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = (state_q == S_DONE);
  assign fail      = fail_q;
  assign fail_addr = fail_addr_q;
  assign fail_elem = fail_elem_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    rd_pend_d   = is_rd;
    rd_exp_d    = bg;
    rd_addr_d   = addr_q;
    rd_elem_d   = elem;

    if (last_op) begin
      addr_d = at_end ? reload : (up ? addr_q + ADDR_ONE : addr_q - ADDR_ONE);
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_M0;
          addr_d      = ADDR_ZERO;
          fail_d      = 1'b0;
          fail_addr_d = ADDR_ZERO;
          fail_elem_d = 3'd0;
        end
      end
      S_M0:    if (at_end) state_d = S_M1R;
      S_M1R:   state_d = S_M1W;
      S_M1W:   state_d = at_end ? S_M2R : S_M1R;
      S_M2R:   state_d = S_M2W;
      S_M2W:   state_d = at_end ? S_M3R : S_M2R;
      S_M3R:   state_d = S_M3W;
      S_M3W:   state_d = at_end ? S_M4R : S_M3R;
      S_M4R:   state_d = S_M4W;
      S_M4W:   state_d = at_end ? S_M5 : S_M4R;
      S_M5:    if (at_end) state_d = S_DRAIN;
      S_DRAIN: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    if (mismatch) begin
      fail_d = 1'b1;
      if (!fail_q) begin
        fail_addr_d = rd_addr_q;
        fail_elem_d = rd_elem_q;
      end
`ifdef BIST_EARLY_STOP_EN
      // Abort: drop any read still in flight so DONE starts clean.
      state_d   = S_DONE;
      addr_d    = ADDR_ZERO;
      rd_pend_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= 3'd0;
      rd_pend_q   <= 1'b0;
      rd_exp_q    <= 1'b0;
      rd_addr_q   <= '0;
      rd_elem_q   <= 3'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      rd_pend_q   <= rd_pend_d;
      rd_exp_q    <= rd_exp_d;
      rd_addr_q   <= rd_addr_d;
      rd_elem_q   <= rd_elem_d;
    end
  end

endmodule

// File: tb/tb_march_bist_ctrl.sv
// tb/tb_march_bist_ctrl.sv - directed table-driven bench for march_bist_ctrl
module tb_march_bist_ctrl;

`ifdef BIST_EARLY_STOP_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  localparam int NOPS = 161;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] mem_addr;
  logic [3:0] mem_wdata;
  logic       mem_we;
  logic       mem_re;
  logic [3:0] mem_rdata = 4'd0;
  logic       busy;
  logic       done;
  logic       fail;
  logic [3:0] fail_addr;
  logic [2:0] fail_elem;

  march_bist_ctrl #(.data_width(4), .ad_width(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .busy(busy), .done(done), .fail(fail),
    .fail_addr(fail_addr), .fail_elem(fail_elem)
  );

  always #5 clk = ~clk;

  // Memory model with an optional stuck-at fault on one cell.
  logic [3:0] mem [16];
  logic       fault_en = 1'b0;
  logic [3:0] fault_addr = 4'd0;
  logic [3:0] fault_mask = 4'd0;
  logic       fault_val = 1'b0;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) begin
      if (fault_en && mem_addr == fault_addr)
        mem_rdata <= fault_val ? (mem[mem_addr] | fault_mask) : (mem[mem_addr] & ~fault_mask);
      else
        mem_rdata <= mem[mem_addr];
    end
  end

  int conflicts = 0;
  always @(negedge clk) if (mem_we && mem_re) conflicts++;

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference op sequence built straight from the algorithm text.
  typedef struct {
    logic       we;
    logic       re;
    logic [3:0] addr;
    logic [3:0] wd;
  } op_t;
  op_t exp_ops [NOPS];

  typedef struct {
    bit         fault;
    bit         fval;
    logic [3:0] faddr;
    logic [3:0] fmask;
    int         restart;
    logic       exp_fail;
    logic [3:0] exp_faddr;
    logic [2:0] exp_felem;
  } vec_t;
  vec_t vecs [5];

  function automatic int exp_cycles(input vec_t v);
    if (!v.fault || !EARLY) return NOPS;
    return 16 + 32 * (int'(v.exp_felem) - 1) + 2 * int'(v.exp_faddr) + 2;
  endfunction

  task automatic run_vec(input vec_t v, input int vi);
    int cyc;
    int serr;
    int late_we;
    fault_en   = v.fault;
    fault_val  = v.fval;
    fault_addr = v.faddr;
    fault_mask = v.fmask;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk($sformatf("v%0d_cleared_done", vi), done, 0);
    chk($sformatf("v%0d_cleared_fail", vi), fail, 0);
    cyc = 0;
    serr = 0;
    while (busy && cyc < 400) begin
      if (cyc < NOPS) begin
        if (mem_we !== exp_ops[cyc].we || mem_re !== exp_ops[cyc].re) serr++;
        else if ((mem_we || mem_re) && mem_addr !== exp_ops[cyc].addr) serr++;
        else if (mem_we && mem_wdata !== exp_ops[cyc].wd) serr++;
      end
      start = (cyc == v.restart);
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    chk($sformatf("v%0d_busy_cycles", vi), cyc, exp_cycles(v));
    chk($sformatf("v%0d_done", vi), done, 1);
    chk($sformatf("v%0d_fail", vi), fail, v.exp_fail);
    chk($sformatf("v%0d_fail_addr", vi), fail_addr, v.exp_faddr);
    chk($sformatf("v%0d_fail_elem", vi), fail_elem, v.exp_felem);
    chk($sformatf("v%0d_op_seq_errors", vi), serr, 0);
    late_we = 0;
    repeat (3) begin
      @(negedge clk);
      if (mem_we || mem_re || busy || !done) late_we++;
    end
    chk($sformatf("v%0d_quiet_after_done", vi), late_we, 0);
  endtask

  initial begin
    int idx;
    int cyc;
    rst = 1'b0;
    start = 1'b0;

    idx = 0;
    for (int k = 0; k < 16; k++) exp_ops[idx++] = '{1'b1, 1'b0, 4'(k), 4'h0};
    for (int e = 1; e <= 4; e++) begin
      for (int k = 0; k < 16; k++) begin
        logic [3:0] a;
        logic       rb;
        a  = (e <= 2) ? 4'(k) : 4'(15 - k);
        rb = (e == 2 || e == 4);
        exp_ops[idx++] = '{1'b0, 1'b1, a, 4'h0};
        exp_ops[idx++] = '{1'b1, 1'b0, a, rb ? 4'h0 : 4'hF};
      end
    end
    for (int k = 0; k < 16; k++) exp_ops[idx++] = '{1'b0, 1'b1, 4'(15 - k), 4'h0};
    exp_ops[idx] = '{1'b0, 1'b0, 4'h0, 4'h0};

    //            fault fval faddr fmask  restart fail faddr felem
    vecs[0] = '{1'b0, 1'b0, 4'd0,  4'h0, -1,     1'b0, 4'd0,  3'd0};
    vecs[1] = '{1'b1, 1'b0, 4'd5,  4'h4, -1,     1'b1, 4'd5,  3'd2};
    vecs[2] = '{1'b0, 1'b0, 4'd0,  4'h0, 40,     1'b0, 4'd0,  3'd0};
    vecs[3] = '{1'b1, 1'b0, 4'd15, 4'h8, 40,     1'b1, 4'd15, 3'd2};
    vecs[4] = '{1'b1, 1'b1, 4'd0,  4'h1, -1,     1'b1, 4'd0,  3'd1};

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fail", fail, 0);
    chk("rst_strobes", {mem_we, mem_re}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_diag", {fail_addr, fail_elem}, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", busy, 0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Reset in the middle of a run, during an M2 write cycle.
    fault_en = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (71) @(negedge clk);
    chk("midrun_we_before_rst", mem_we, 1);
    rst = 1'b0;
    #1;
    chk("midrun_rst_we", mem_we, 0);
    chk("midrun_rst_outputs", {busy, done, fail, mem_re, mem_addr, mem_wdata, fail_addr, fail_elem}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy || done || mem_we || mem_re) cyc++;
    end
    chk("after_rst_stays_idle", cyc, 0);

    // Start held high for a whole run: ignored mid-run and at the DONE-entry
    // edge, honoured one edge later from DONE.
    @(negedge clk); start = 1'b1;
    @(negedge clk);
    cyc = 0;
    while (busy && cyc < 400) begin
      cyc++;
      @(negedge clk);
    end
    chk("held_start_cycles", cyc, NOPS);
    chk("held_start_done", done, 1);
    @(negedge clk);
    chk("restart_from_done_busy", busy, 1);
    chk("restart_from_done_clears_done", done, 0);
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 400) begin
      cyc++;
      @(negedge clk);
    end
    chk("second_run_cycles", cyc, NOPS);
    chk("second_run_fail", fail, 0);

    chk("we_re_conflicts", conflicts, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
